ifetch_responder: RTL and testbench

Instruction-side memory responder for the 65HE06 core. Sits between the fetch unit and a single-ported 16-bit instruction memory bus. Answers each fetch request (`pc_in`, `pf_in`) with three words: opcode, argument and prefetch opcode. Holds the fetch unit while words are missing, and reuses already-buffered words so sequential flow costs at most one bus beat per instruction.

---
 rtl/he06_pkg.sv | 19 +
 rtl/ifr_slot_match.sv | 53 +++++
 rtl/ifetch_responder.sv | 114 +++++++++++
 tb/tb_ifetch_responder.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/he06_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// he06_pkg : shared types for the 65HE06 instruction-side blocks
// Revision : 1.0
// ----------------------------------------------------------------------------
package he06_pkg;

  typedef logic [15:0] word_t;
  typedef logic [14:0] waddr_t;

  typedef enum logic [0:0] {
    IFR_IDLE = 1'b0,
    IFR_REQ  = 1'b1
  } ifr_state_t;

  localparam int IFR_SLOTS = 3;

endpackage
`default_nettype wire

// File: rtl/ifr_slot_match.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ifr_slot_match : matches 3 needed word addresses against 3 buffer slots
// Revision       : 1.0
// ----------------------------------------------------------------------------
module ifr_slot_match
  import he06_pkg::*;
(
  input  waddr_t [IFR_SLOTS-1:0] need,
  input  logic   [IFR_SLOTS-1:0] slot_valid,
  input  waddr_t [IFR_SLOTS-1:0] slot_addr,
  input  word_t  [IFR_SLOTS-1:0] slot_data,
  output logic   [IFR_SLOTS-1:0] need_hit,
  output word_t  [IFR_SLOTS-1:0] need_word,
  output logic   [1:0]           miss_idx,
  output logic   [1:0]           victim_idx,
  output logic                   victim_ok
);

  logic [IFR_SLOTS-1:0] hit [IFR_SLOTS];
  logic [IFR_SLOTS-1:0] slot_used;

  for (genvar n = 0; n < IFR_SLOTS; n++) begin : g_need
    for (genvar s = 0; s < IFR_SLOTS; s++) begin : g_slot
      assign hit[n][s] = slot_valid[s] && (slot_addr[s] == need[n]);
    end
    assign need_hit[n] = |hit[n];
  end

  // Descending loops so the lowest matching index wins.
  always_comb begin
    need_word  = '0;
    miss_idx   = '0;
    victim_idx = '0;
    victim_ok  = 1'b0;
    slot_used  = '0;
    for (int n = IFR_SLOTS - 1; n >= 0; n--) begin
      if (!need_hit[n]) miss_idx = 2'(n);
      slot_used = slot_used | hit[n];
      for (int s = IFR_SLOTS - 1; s >= 0; s--) begin
        if (hit[n][s]) need_word[n] = slot_data[s];
      end
    end
    for (int s = IFR_SLOTS - 1; s >= 0; s--) begin
      if (!slot_used[s]) begin
        victim_idx = 2'(s);
        victim_ok  = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ifetch_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ifetch_responder : 3-slot instruction word buffer with single-port bus fill
// Revision         : 1.0
// ----------------------------------------------------------------------------
module ifetch_responder
  import he06_pkg::*;
#(
  parameter int MEM_LAT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pc_in,
  input  logic [15:0] pf_in,
  input  logic        flush,
  output logic [15:0] fetch_opc,
  output logic [15:0] fetch_arg,
  output logic [15:0] prefetch_opc,
  output logic        hold,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        mem_err
);

  localparam int CW = $clog2(MEM_LAT_MAX + 2);
  localparam logic [CW-1:0] LAT_SAT = CW'(MEM_LAT_MAX + 1);
  localparam logic [CW-1:0] LAT_MAX = CW'(MEM_LAT_MAX);

  ifr_state_t             state, state_nxt;
  logic   [IFR_SLOTS-1:0] slot_valid;
  waddr_t [IFR_SLOTS-1:0] slot_addr;
  word_t  [IFR_SLOTS-1:0] slot_data;
  waddr_t [IFR_SLOTS-1:0] need;
  logic   [IFR_SLOTS-1:0] need_hit;
  word_t  [IFR_SLOTS-1:0] need_word;
  logic   [1:0]           miss_idx;
  logic   [1:0]           victim_idx;
  logic                   victim_ok;
  waddr_t                 req_addr;
  logic                   discard;
  logic   [CW-1:0]        lat_cnt, lat_nxt;
  logic                   unused_lsb;

  // Word addresses; 15-bit wrap is the same as 16-bit byte wrap.
  assign need[0]    = pc_in[15:1];
  assign need[1]    = pc_in[15:1] + 15'd1;
  assign need[2]    = pf_in[15:1] + 15'd1;
  assign unused_lsb = pc_in[0] ^ pf_in[0];

  ifr_slot_match u_match (
    .need       (need),
    .slot_valid (slot_valid),
    .slot_addr  (slot_addr),
    .slot_data  (slot_data),
    .need_hit   (need_hit),
    .need_word  (need_word),
    .miss_idx   (miss_idx),
    .victim_idx (victim_idx),
    .victim_ok  (victim_ok)
  );

  assign fetch_opc    = need_word[0];
  assign fetch_arg    = need_word[1];
  assign prefetch_opc = need_word[2];
  assign hold         = !(&need_hit) || (state != IFR_IDLE);
  assign mem_req      = (state == IFR_REQ);
  assign mem_addr     = {req_addr, 1'b0};
  assign lat_nxt      = (lat_cnt < LAT_SAT) ? lat_cnt + CW'(1) : lat_cnt;

  always_comb begin
    state_nxt = state;
    case (state)
      IFR_IDLE: if (!(&need_hit)) state_nxt = IFR_REQ;
      IFR_REQ:  if (mem_ack) state_nxt = IFR_IDLE;
      default:  state_nxt = IFR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IFR_IDLE;
      slot_valid <= '0;
      slot_addr  <= '0;
      slot_data  <= '0;
      req_addr   <= '0;
      discard    <= 1'b0;
      lat_cnt    <= '0;
      mem_err    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IFR_IDLE && state_nxt == IFR_REQ) begin
        req_addr <= need[miss_idx];
        discard  <= 1'b0;
        lat_cnt  <= '0;
      end else if (state == IFR_REQ) begin
        lat_cnt <= lat_nxt;
        if (lat_nxt > LAT_MAX) mem_err <= 1'b1;
        if (flush) discard <= 1'b1;
      end
      // A beat overlapping a flush may carry pre-flush data, so it is dropped.
      if (flush) begin
        slot_valid <= '0;
      end else if (state == IFR_REQ && mem_ack && !discard && victim_ok) begin
        slot_valid[victim_idx] <= 1'b1;
        slot_addr[victim_idx]  <= req_addr;
        slot_data[victim_idx]  <= mem_rdata;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ifetch_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_ifetch_responder : directed + randomized bench with a memory model
// Revision            : 1.0
// ----------------------------------------------------------------------------
module tb_ifetch_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc_in, pf_in;
  logic        flush;
  logic [15:0] fetch_opc, fetch_arg, prefetch_opc;
  logic        hold, mem_req, mem_ack, mem_err;
  logic [15:0] mem_addr, mem_rdata;

  logic [15:0] mem [0:32767];
  logic [15:0] beats [$];
  int          lat;
  int          total = 0;
  int          bad   = 0;

  ifetch_responder #(.MEM_LAT_MAX(15)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_in        (pc_in),
    .pf_in        (pf_in),
    .flush        (flush),
    .fetch_opc    (fetch_opc),
    .fetch_arg    (fetch_arg),
    .prefetch_opc (prefetch_opc),
    .hold         (hold),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .mem_err      (mem_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [15:0] rd(input logic [15:0] a);
    return mem[a[15:1]];
  endfunction

  task automatic settle(output int cyc);
    cyc = 0;
    #1;
    while (hold && cyc < 300) begin
      cyc++;
      tick();
    end
    check("settle", hold, 1'b0);
  endtask

  task automatic wait_req();
    int n = 0;
    while (!mem_req && n < 100) begin
      n++;
      tick();
    end
    check("req_seen", mem_req, 1'b1);
  endtask

  task automatic check_words(input string tag);
    logic [15:0] a1, a2;
    a1 = pc_in + 16'd2;
    a2 = pf_in + 16'd2;
    check({tag, "_opc"}, fetch_opc, rd(pc_in));
    check({tag, "_arg"}, fetch_arg, rd(a1));
    check({tag, "_pre"}, prefetch_opc, rd(a2));
  endtask

  // Bus model: acks after lat cycles of mem_req, data from mem at ack time.
  initial begin
    int          wcnt = 0;
    logic [15:0] cap  = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (mem_req === 1'b1) begin
        if (wcnt == 0) cap = mem_addr;
        else check("addr_stable", mem_addr, cap);
        if (wcnt == lat) begin
          mem_ack   = 1'b1;
          mem_rdata = rd(mem_addr);
          beats.push_back(mem_addr);
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  initial begin
    int          cyc;
    logic [15:0] n1, n2;
    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom) | 16'd1;
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;
    mem[15'h7FFF] = 16'hABCD;
    rst = 1'b1; pc_in = 16'h0000; pf_in = 16'h0002; flush = 1'b0; lat = 0;
    repeat (3) tick();
    check("rst_req", mem_req, 1'b0);
    check("rst_addr", mem_addr, 16'h0000);
    check("rst_err", mem_err, 1'b0);
    check("rst_hold", hold, 1'b1);
    check("rst_opc", fetch_opc, 16'h0000);
    check("rst_pre", prefetch_opc, 16'h0000);

    // cold start: three beats
    beats.delete();
    rst = 1'b0;
    settle(cyc);
    check("cold_cyc", cyc, 6);
    check("cold_beats", beats.size(), 3);
    if (beats.size() == 3) begin
      check("cold_b0", beats[0], 16'h0000);
      check("cold_b1", beats[1], 16'h0002);
      check("cold_b2", beats[2], 16'h0004);
    end
    check("cold_opc", fetch_opc, 16'h1111);
    check("cold_arg", fetch_arg, 16'h2222);
    check("cold_pre", prefetch_opc, 16'h3333);

    // sequential step: one new word
    beats.delete();
    pc_in = 16'h0002; pf_in = 16'h0004;
    settle(cyc);
    check("seq_cyc", cyc, 2);
    check("seq_beats", beats.size(), 1);
    if (beats.size() == 1) check("seq_b0", beats[0], 16'h0006);
    check("seq_pre", prefetch_opc, 16'h4444);
    check_words("seq");

    // wrap: N1 == N2 == 0x0000
    beats.delete();
    pc_in = 16'hFFFE; pf_in = 16'hFFFE;
    settle(cyc);
    check("wrap_beats", beats.size(), 2);
    if (beats.size() == 2) begin
      check("wrap_b0", beats[0], 16'hFFFE);
      check("wrap_b1", beats[1], 16'h0000);
    end
    check("wrap_opc", fetch_opc, 16'hABCD);
    check("wrap_arg", fetch_arg, 16'h1111);

    // zero-latency hit
    beats.delete();
    pc_in = 16'hFFFE; pf_in = 16'hFFFC;
    #1;
    check("hit_hold", hold, 1'b0);
    check("hit_pre", prefetch_opc, 16'hABCD);
    tick();
    check("hit_beats", beats.size(), 0);

    // flush while in REQ: in-flight word dropped, all three refetched
    lat = 3;
    pc_in = 16'h0100; pf_in = 16'h0102;
    wait_req();
    tick();
    beats.delete();
    mem[15'h0080] = 16'h5A01; mem[15'h0081] = 16'h5A02; mem[15'h0082] = 16'h5A03;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_hold", hold, 1'b1);
    settle(cyc);
    check("flush_beats", beats.size(), 4);
    check("flush_opc", fetch_opc, 16'h5A01);
    check_words("flush");

    // timeout
    lat = 20;
    pc_in = 16'h0200; pf_in = 16'h0200;
    wait_req();
    repeat (15) tick();
    check("err_early", mem_err, 1'b0);
    tick();
    check("err_set", mem_err, 1'b1);
    settle(cyc);
    check("err_sticky", mem_err, 1'b1);

    // reset in the middle of a REQ
    pc_in = 16'h0300; pf_in = 16'h0300;
    wait_req();
    repeat (2) tick();
    rst = 1'b1; pc_in = 16'h0200; pf_in = 16'h0200;
    tick();
    check("mrst_req", mem_req, 1'b0);
    check("mrst_err", mem_err, 1'b0);
    check("mrst_hold", hold, 1'b1);
    check("mrst_opc", fetch_opc, 16'h0000);
    check("mrst_arg", fetch_arg, 16'h0000);
    lat = 1;
    beats.delete();
    rst = 1'b0;
    settle(cyc);
    check("mrst_beats", beats.size(), 2);
    check("mrst_cyc", cyc, 6);
    check_words("mrst");

    // randomized requests, occasional flush with memory rewrite
    for (int it = 0; it < 160; it++) begin
      bit do_fl;
      int d;
      bit dup, allneed;
      lat = $urandom_range(0, 4);
      if ($urandom_range(0, 4) == 0) pc_in = 16'hFFFA + 16'(2 * $urandom_range(0, 2));
      else pc_in = 16'h0400 + 16'(2 * $urandom_range(0, 7));
      pf_in = pc_in + 16'(2 * $urandom_range(0, 3)) - 16'd2;
      do_fl = ($urandom_range(0, 5) == 0);
      d = $urandom_range(0, 2);
      beats.delete();
      n1 = pc_in + 16'd2;
      n2 = pf_in + 16'd2;
      if (do_fl) begin
        repeat (d) tick();
        mem[pc_in[15:1]] = 16'($urandom);
        mem[n2[15:1]] = 16'($urandom);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        settle(cyc);
      end else begin
        settle(cyc);
        check("rnd_cyc", cyc, beats.size() * (lat + 2));
        dup = 1'b0;
        allneed = 1'b1;
        for (int i = 0; i < beats.size(); i++) begin
          if (beats[i] != pc_in && beats[i] != n1 && beats[i] != n2) allneed = 1'b0;
          for (int j = i + 1; j < beats.size(); j++)
            if (beats[i] == beats[j]) dup = 1'b1;
        end
        check("rnd_dup", dup, 1'b0);
        check("rnd_need", allneed, 1'b1);
      end
      check_words("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
